// File: rtl/l_writer.sv
// Column-stream transmitter for L glyphs: emits one blank lead column, then
// 111/001/000 per letter, with optional inter-letter gap columns.
module l_writer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         restart_n,
  input  logic         start,
  input  logic [W-1:0] count,
  input  logic         pause,
  output logic [2:0]   bits,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sent
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    COL1 = 3'd2,
    COL2 = 3'd3,
    COL3 = 3'd4,
    GAP  = 3'd5
  } state_t;

  state_t       state;
  state_t       nxt;
  logic [W-1:0] remaining;

  function automatic logic [2:0] col_of(input state_t s);
    case (s)
      COL1:    col_of = 3'b111;
      COL2:    col_of = 3'b001;
      default: col_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start && (count != '0)) nxt = LEAD;
      LEAD: nxt = COL1;
      COL1: nxt = COL2;
      COL2: nxt = COL3;
      // Only the end column of a letter may be followed by gap columns.
      COL3: begin
        if (remaining == W'(1)) nxt = IDLE;
        else if (pause)         nxt = GAP;
        else                    nxt = COL1;
      end
      GAP:  if (!pause) nxt = COL1;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!restart_n) begin
      state     <= IDLE;
      bits      <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent      <= '0;
      remaining <= '0;
    end else begin
      state <= nxt;
      bits  <= col_of(nxt);
      busy  <= (nxt != IDLE);
      done  <= (nxt == COL3) && (remaining == W'(1));
      if (state == IDLE && nxt == LEAD) begin
        remaining <= count;
        sent      <= '0;
      end else if (state == COL3) begin
        remaining <= remaining - W'(1);
        sent      <= sent + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_l_writer.sv
// Directed bench for l_writer: each step advances one clock and checks the
// full output vector against hand-computed values.
module tb_l_writer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         restart_n;
  logic         start;
  logic [W-1:0] count;
  logic         pause;
  logic [2:0]   bits;
  logic         busy;
  logic         done;
  logic [W-1:0] sent;

  int tests  = 0;
  int failed = 0;

  l_writer #(.W(W)) dut (
    .clk       (clk),
    .restart_n (restart_n),
    .start     (start),
    .count     (count),
    .pause     (pause),
    .bits      (bits),
    .busy      (busy),
    .done      (done),
    .sent      (sent)
  );

  always #5 clk = ~clk;

  // Reference L-recognizer: counts 111,001,000 column triplets on the stream.
  logic [2:0] h1 = 3'b000;
  logic [2:0] h2 = 3'b000;
  int         lcount = 0;
  always @(posedge clk) begin
    h2 <= h1;
    h1 <= bits;
    if (h2 == 3'b111 && h1 == 3'b001 && bits == 3'b000) lcount <= lcount + 1;
  end

  task automatic step(input string tag, input logic [2:0] b, input logic by,
                      input logic d, input logic [W-1:0] s);
    @(posedge clk);
    #1;
    tests++;
    assert ({bits, busy, done, sent} === {b, by, d, s}) else begin
      failed++;
      $error("FAIL %s: observed bits=%b busy=%b done=%b sent=%0d expected bits=%b busy=%b done=%b sent=%0d",
             tag, bits, busy, done, sent, b, by, d, s);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int l0;

  initial begin
    restart_n = 1'b0;
    start     = 1'b0;
    count     = '0;
    pause     = 1'b0;

    // Reset then idle
    step("rst_hold1", 3'b000, 1'b0, 1'b0, 4'd0);
    step("rst_hold2", 3'b000, 1'b0, 1'b0, 4'd0);
    restart_n = 1'b1;
    step("idle1", 3'b000, 1'b0, 1'b0, 4'd0);
    step("idle2", 3'b000, 1'b0, 1'b0, 4'd0);

    // Single letter
    l0 = lcount;
    count = 4'd1; start = 1'b1;
    step("s1_lead", 3'b000, 1'b1, 1'b0, 4'd0);
    start = 1'b0;
    step("s1_c1",   3'b111, 1'b1, 1'b0, 4'd0);
    step("s1_c2",   3'b001, 1'b1, 1'b0, 4'd0);
    step("s1_c3",   3'b000, 1'b1, 1'b1, 4'd0);
    step("s1_idle", 3'b000, 1'b0, 1'b0, 4'd1);
    check_int("s1_reader", lcount - l0, 1);

    // Three letters back-to-back
    l0 = lcount;
    count = 4'd3; start = 1'b1;
    step("s3_lead", 3'b000, 1'b1, 1'b0, 4'd0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("s3_l%0d_c1", i), 3'b111, 1'b1, 1'b0, W'(i));
      step($sformatf("s3_l%0d_c2", i), 3'b001, 1'b1, 1'b0, W'(i));
      step($sformatf("s3_l%0d_c3", i), 3'b000, 1'b1, (i == 2), W'(i));
    end
    step("s3_idle", 3'b000, 1'b0, 1'b0, 4'd3);
    check_int("s3_reader", lcount - l0, 3);

    // Pause: ignored during LEAD/COL1/COL2, three gap columns after letter 1
    l0 = lcount;
    count = 4'd2; start = 1'b1; pause = 1'b1;
    step("p_lead",  3'b000, 1'b1, 1'b0, 4'd0);
    start = 1'b0;
    step("p_c1",    3'b111, 1'b1, 1'b0, 4'd0);
    step("p_c2",    3'b001, 1'b1, 1'b0, 4'd0);
    step("p_c3",    3'b000, 1'b1, 1'b0, 4'd0);
    step("p_gap1",  3'b000, 1'b1, 1'b0, 4'd1);
    step("p_gap2",  3'b000, 1'b1, 1'b0, 4'd1);
    step("p_gap3",  3'b000, 1'b1, 1'b0, 4'd1);
    pause = 1'b0;
    step("p_l1_c1", 3'b111, 1'b1, 1'b0, 4'd1);
    step("p_l1_c2", 3'b001, 1'b1, 1'b0, 4'd1);
    step("p_l1_c3", 3'b000, 1'b1, 1'b1, 4'd1);
    step("p_idle",  3'b000, 1'b0, 1'b0, 4'd2);
    check_int("p_reader", lcount - l0, 2);

    // start with count=0 is ignored
    count = 4'd0; start = 1'b1;
    step("z_idle1", 3'b000, 1'b0, 1'b0, 4'd2);
    step("z_idle2", 3'b000, 1'b0, 1'b0, 4'd2);

    // start/count changes while busy are ignored
    count = 4'd2;
    step("b_lead",  3'b000, 1'b1, 1'b0, 4'd0);
    count = 4'd5;
    step("b_c1",    3'b111, 1'b1, 1'b0, 4'd0);
    step("b_c2",    3'b001, 1'b1, 1'b0, 4'd0);
    step("b_c3",    3'b000, 1'b1, 1'b0, 4'd0);
    step("b_l1_c1", 3'b111, 1'b1, 1'b0, 4'd1);
    step("b_l1_c2", 3'b001, 1'b1, 1'b0, 4'd1);
    step("b_l1_c3", 3'b000, 1'b1, 1'b1, 4'd1);
    start = 1'b0;
    step("b_idle",  3'b000, 1'b0, 1'b0, 4'd2);

    // Mid-transfer reset during COL2 of letter 2 of 4
    count = 4'd4; start = 1'b1;
    step("r_lead",  3'b000, 1'b1, 1'b0, 4'd0);
    start = 1'b0;
    step("r_c1",    3'b111, 1'b1, 1'b0, 4'd0);
    step("r_c2",    3'b001, 1'b1, 1'b0, 4'd0);
    step("r_c3",    3'b000, 1'b1, 1'b0, 4'd0);
    step("r_l1_c1", 3'b111, 1'b1, 1'b0, 4'd1);
    step("r_l1_c2", 3'b001, 1'b1, 1'b0, 4'd1);
    restart_n = 1'b0;
    step("r_reset", 3'b000, 1'b0, 1'b0, 4'd0);
    restart_n = 1'b1;
    step("r_idle",  3'b000, 1'b0, 1'b0, 4'd0);
    count = 4'd1; start = 1'b1;
    step("r2_lead", 3'b000, 1'b1, 1'b0, 4'd0);
    start = 1'b0;
    step("r2_c1",   3'b111, 1'b1, 1'b0, 4'd0);
    step("r2_c2",   3'b001, 1'b1, 1'b0, 4'd0);
    step("r2_c3",   3'b000, 1'b1, 1'b1, 4'd0);
    step("r2_idle", 3'b000, 1'b0, 1'b0, 4'd1);

    // Reset has priority over start
    count = 4'd3; start = 1'b1; restart_n = 1'b0;
    step("pri_rst", 3'b000, 1'b0, 1'b0, 4'd0);
    start = 1'b0; restart_n = 1'b1;
    step("pri_idle", 3'b000, 1'b0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/l_writer.md
# l_writer

Transmitter for the 3-bit column stream consumed by the L-recognizer. On a start request it emits a programmable number of "L" glyphs as a well-formed column sequence: one leading blank, then 111, 001, 000 per letter. The output stream is registered, one column per clock, with an idle value of blank (000). It sits upstream of the letter reader, either as a stimulus source or as the glyph output of a display path.

## Interface
- W, default 4: width of the letter-count request and of the sent counter.
- clk  input  1  clock; all state changes on the rising edge.
- restart_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request to send; sampled only in IDLE.
- count  input  W  number of letters to send; latched when start is accepted.
- pause  input  1  inter-letter stall request; sampled only at letter boundaries.
- bits  output  3  current column (registered).
- busy  output  1  high while a transfer is in progress (registered).
- done  output  1  one-cycle pulse coinciding with the final column of the transfer (registered).
- sent  output  W  number of letters completed in the current or most recent transfer.

## Operation
- States: IDLE, LEAD, COL1, COL2, COL3, GAP. The state is one-hot or encoded; the encoding is not externally visible.
- Column driven on bits in each state:
  - IDLE, LEAD, COL3, GAP: 000.
  - COL1: 111.
  - COL2: 001.
- Transitions:
  - IDLE: if start=1 and count!=0, latch remaining=count, clear sent, and go to LEAD. Otherwise stay.
  - start with count=0 is ignored: no busy, no done.
  - LEAD → COL1 → COL2 → COL3, unconditionally.
- Leaving COL3:
  - sent increments.
  - remaining decrements.
  - If this was the last letter (remaining was 1), done=1 in this cycle and the next state is IDLE.
  - Else if pause=1, go to GAP.
  - Else go to COL1, so letters are back-to-back: 111,001,000,111,…
- GAP: stay while pause=1; go to COL1 when pause=0.
- pause is ignored in LEAD, COL1 and COL2. A glyph is never split, because extra 000 columns are only legal after a letter's end column.
- start is ignored while busy=1; count changes mid-transfer have no effect.
- busy=1 in LEAD, COL1, COL2, COL3 and GAP; 0 in IDLE.
- sent holds its final value in IDLE until the next accepted start.
- Arithmetic:
  - remaining and sent are W bits.
  - sent never exceeds count, so no wrap occurs.
  - Maximum transfer is 2^W−1 letters.

## Timing
- Reset: restart_n=0 at an edge forces IDLE at that edge. All outputs then read:
  - bits=000
  - busy=0
  - done=0
  - sent=0
- Reset applies mid-transfer and the transfer is abandoned; the stream ends on a blank column.
- Reset has priority over start.
- Latency: start accepted at edge k → bits=000 (LEAD) and busy=1 during cycle k+1, then 111 at k+2, 001 at k+3, 000 at k+4.
- For N letters with pause=0 throughout, a transfer lasts 1+3N cycles: busy is high for exactly 1+3N cycles, and done is high in the last of them.
- The cycle after done: busy=0, and a new start may be accepted at that same edge. Back-to-back transfers therefore have 1 idle cycle between them.
- sent updates on the edge leaving COL3, so it is visible one cycle after each end column.
- Pause sampled in COL3 adds one GAP cycle (000) per cycle pause stays high, starting the cycle after COL3.
- A downstream L-recognizer clocked from the same clk flags exactly N letters per transfer, regardless of pause.

## Test plan
- Reset then idle: hold restart_n=0 for 2 cycles, then 1 → bits=000, busy=0, done=0, sent=0, and they stay so with start=0.
- Single letter: count=1, start for 1 cycle → bits 000,111,001,000. busy=1 for 4 cycles; done=1 on the 4th; then sent=1.
- Three letters, no pause: count=3 → bits 000,111,001,000,111,001,000,111,001,000. busy is 10 cycles, done on cycle 10, sent=3. A connected reader pulses L 3 times.
- Pause: count=2, pause=1 held for 3 cycles starting at the first COL3 → three extra 000 columns (GAP) between the letters, total busy 10 cycles. pause=1 during COL1/COL2 has no effect.
- Ignored requests: start with count=0 → no busy, no done. start with count=5 issued while busy → no effect on the current transfer or sent.
- Mid-transfer reset: restart_n=0 during COL2 of letter 2 of 4 → next cycle bits=000, busy=0, sent=0, no done pulse. A new start with count=1 then produces the normal 4-cycle sequence.
